// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: sample input and byte output handshakes of the sum accumulator
interface sum_accumulator_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       overflow;
    logic       busy;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_last, overflow, busy
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_last, overflow, busy
    );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums N_SAMPLES bytes and emits the total as two bytes, low byte first
module sum_accumulator #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 16
) (
    input logic              clk,
    input logic              rst_n,
    sum_accumulator_if.slave bus
);
    typedef enum logic [1:0] {ACCUM, EMIT_LO, EMIT_HI} state_t;

    state_t           state, state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic [15:0]      acc_wide;
    logic [7:0]       cnt;
    logic             in_ready, overflow, take, close, done;

    assign take     = bus.in_valid & in_ready;
    assign sum      = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, bus.in_data};
    assign close    = (take && cnt == 8'(N_SAMPLES - 1)) || (bus.flush && (cnt != 8'd0 || take));
    assign done     = state == EMIT_HI && bus.out_ready;
    assign acc_wide = 16'(acc);

    assign bus.in_ready  = in_ready;
    assign bus.overflow  = overflow;
    assign bus.out_valid = state != ACCUM;
    assign bus.busy      = state != ACCUM;
    assign bus.out_last  = state == EMIT_HI;
    assign bus.out_data  = state == EMIT_LO ? acc_wide[7:0] : state == EMIT_HI ? acc_wide[15:8] : 8'd0;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_next;
    end

    // frame closes on the last sample or a non-empty flush; each byte leaves on out_ready
    always_comb begin
        state_next = state;
        unique case (state)
            ACCUM:   state_next = close ? EMIT_LO : ACCUM;
            EMIT_LO: state_next = bus.out_ready ? EMIT_HI : EMIT_LO;
            EMIT_HI: state_next = bus.out_ready ? ACCUM : EMIT_HI;
            default: state_next = ACCUM;
        endcase
    end

    // accumulate accepted samples; clear the frame once its high byte is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            in_ready <= state_next == ACCUM;
            if (done) begin
                acc      <= '0;
                cnt      <= '0;
                overflow <= 1'b0;
            end else if (take) begin
                acc <= sum[ACC_W-1:0];
                cnt <= cnt + 8'd1;
                if (sum[ACC_W]) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed vectors against 16-bit and 9-bit accumulators driven in lockstep
module tb_sum_accumulator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data = 8'd0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    sum_accumulator_if a ();
    sum_accumulator_if b ();

    assign a.in_valid  = in_valid;
    assign a.in_data   = in_data;
    assign a.flush     = flush;
    assign a.out_ready = out_ready;
    assign b.in_valid  = in_valid;
    assign b.in_data   = in_data;
    assign b.flush     = flush;
    assign b.out_ready = out_ready;

    sum_accumulator #(.N_SAMPLES(4), .ACC_W(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    sum_accumulator #(.N_SAMPLES(4), .ACC_W(9))  u9  (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    // samples: s[0] is sent first; fw = flush with last sample, fa = flush cycle after samples
    typedef struct {
        int              n;
        logic [3:0][7:0] s;
        bit              fw;
        bit              fa;
        logic [7:0]      lo16;
        logic [7:0]      hi16;
        bit              ov16;
        logic [7:0]      lo9;
        logic [7:0]      hi9;
        bit              ov9;
    } vec_t;

    vec_t vecs [9];
    vec_t ones;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit fl);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        while (!a.in_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 20) chk("handshake_timeout", guard, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic collect(input logic [7:0] lo16, input logic [7:0] hi16, input bit ov16,
                           input logic [7:0] lo9, input logic [7:0] hi9, input bit ov9);
        chk("lo_valid16", a.out_valid, 1);
        chk("lo_valid9", b.out_valid, 1);
        chk("lo_data16", a.out_data, lo16);
        chk("lo_data9", b.out_data, lo9);
        chk("lo_last16", a.out_last, 0);
        chk("lo_ovf16", a.overflow, ov16);
        chk("lo_ovf9", b.overflow, ov9);
        chk("lo_busy", a.busy, 1);
        chk("lo_in_ready", a.in_ready, 0);
        @(posedge clk);
        #1;
        chk("hi_valid16", a.out_valid, 1);
        chk("hi_data16", a.out_data, hi16);
        chk("hi_data9", b.out_data, hi9);
        chk("hi_last16", a.out_last, 1);
        chk("hi_last9", b.out_last, 1);
        chk("hi_ovf16", a.overflow, ov16);
        chk("hi_ovf9", b.overflow, ov9);
        @(posedge clk);
        #1;
        chk("done_valid16", a.out_valid, 0);
        chk("done_valid9", b.out_valid, 0);
        chk("done_ovf16", a.overflow, 0);
        chk("done_ovf9", b.overflow, 0);
        chk("done_busy", a.busy, 0);
        chk("done_in_ready", a.in_ready, 1);
    endtask

    task automatic run_frame(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            send(v.s[i], v.fw && i == v.n - 1);
            if (i < v.n - 1 || v.fa) chk("early_valid", a.out_valid, 0);
        end
        if (v.fa) flush_pulse();
        chk("latency16", a.out_valid, 1);
        chk("latency9", b.out_valid, 1);
        collect(v.lo16, v.hi16, v.ov16, v.lo9, v.hi9, v.ov9);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, a.out_valid, 0);
        chk({tag, "_data"}, a.out_data, 0);
        chk({tag, "_last"}, a.out_last, 0);
        chk({tag, "_busy"}, a.busy, 0);
        chk({tag, "_in_ready"}, a.in_ready, 0);
        chk({tag, "_ovf9"}, b.overflow, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", a.in_ready, 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", a.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4, {8'd40,  8'd30,  8'd20,  8'd10},  1'b0, 1'b0, 8'h64, 8'h00, 1'b0, 8'h64, 8'h00, 1'b0};
        vecs[1] = '{4, {8'd255, 8'd255, 8'd255, 8'd255}, 1'b0, 1'b0, 8'hFC, 8'h03, 1'b0, 8'hFC, 8'h01, 1'b1};
        vecs[2] = '{2, {8'd0,   8'd0,   8'd7,   8'd5},   1'b0, 1'b1, 8'h0C, 8'h00, 1'b0, 8'h0C, 8'h00, 1'b0};
        vecs[3] = '{3, {8'd0,   8'd3,   8'd7,   8'd5},   1'b1, 1'b0, 8'h0F, 8'h00, 1'b0, 8'h0F, 8'h00, 1'b0};
        vecs[4] = '{1, {8'd0,   8'd0,   8'd0,   8'd9},   1'b1, 1'b0, 8'h09, 8'h00, 1'b0, 8'h09, 8'h00, 1'b0};
        vecs[5] = '{3, {8'd0,   8'd200, 8'd200, 8'd200}, 1'b0, 1'b1, 8'h58, 8'h02, 1'b0, 8'h58, 8'h00, 1'b1};
        vecs[6] = '{4, {8'd0,   8'd0,   8'd0,   8'd0},   1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[7] = '{2, {8'd0,   8'd0,   8'd255, 8'd255}, 1'b0, 1'b1, 8'hFE, 8'h01, 1'b0, 8'hFE, 8'h01, 1'b0};
        vecs[8] = '{3, {8'd0,   8'd2,   8'd255, 8'd255}, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 8'h00, 8'h00, 1'b1};
        ones    = '{4, {8'd1,   8'd1,   8'd1,   8'd1},   1'b0, 1'b0, 8'h04, 8'h00, 1'b0, 8'h04, 8'h00, 1'b0};

        #1;
        check_reset_outputs("por");
        release_reset();

        flush_pulse();
        chk("empty_flush_valid", a.out_valid, 0);
        chk("empty_flush_in_ready", a.in_ready, 1);

        foreach (vecs[i]) run_frame(vecs[i]);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(vecs[0].s[i], 1'b0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'd99;
            flush    = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            flush    = 1'b0;
            chk("bp_data", a.out_data, 8'h64);
            chk("bp_valid", a.out_valid, 1);
            chk("bp_last", a.out_last, 0);
            chk("bp_in_ready", a.in_ready, 0);
        end
        out_ready = 1'b1;
        collect(8'h64, 8'h00, 1'b0, 8'h64, 8'h00, 1'b0);
        run_frame(ones);

        send(8'd50, 1'b0);
        send(8'd60, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        release_reset();
        run_frame(vecs[0]);

        for (int i = 0; i < 4; i++) send(vecs[1].s[i], 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_last", a.out_last, 1);
        chk("pre_rst_ovf9", b.overflow, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_emit");
        release_reset();
        chk("post_rst_valid", a.out_valid, 0);
        run_frame(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
Downstream stage of the byte adder in the tt_um top. It consumes the 8-bit sum stream through a valid/ready handshake and accumulates N_SAMPLES sums into an ACC_W-bit register. Each completed (or flushed) total is emitted as two bytes, low byte first, on an 8-bit valid/ready output. The output feeds uo_out and uio_out, so the team can read multi-sample totals through the 8-bit pins.

Parameters:
N_SAMPLES, 4, samples per frame; legal range 2..255
ACC_W, 16, accumulator width; legal range 9..16; wraps modulo 2^ACC_W

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data holds a sum
in_ready  output  1  block accepts a sample this cycle
in_data  input  8  unsigned sum from adder stage
flush  input  1  close current partial frame early
out_valid  output  1  out_data holds an output byte
out_ready  input  1  consumer accepts the byte
out_data  output  8  result byte
out_last  output  1  marks the high (second) byte
overflow  output  1  sticky: current frame wrapped past 2^ACC_W
busy  output  1  high in EMIT_LO or EMIT_HI

Behaviour:
- Reset (async assert, sync release):
  - state=ACCUM; acc=0; cnt=0.
  - Outputs: overflow=0, out_valid=0, out_data=0, out_last=0, busy=0, in_ready=0.
  - in_ready is a register. It rises on the first clk edge after rst_n deasserts.
- Input handshake: a sample is taken on a rising edge where in_valid & in_ready.
- ACCUM state:
  - in_ready=1.
  - On handshake: acc <= acc + zero-extended in_data (ACC_W bits); cnt <= cnt+1.
  - If the add carries out of bit ACC_W-1, overflow <= 1.
- ACCUM -> EMIT_LO on either condition:
  - a handshake with cnt==N_SAMPLES-1;
  - flush=1 with (cnt>0 or a handshake this cycle). A sample handshaken in the flush cycle is included.
- Flush edge cases:
  - flush with cnt==0 and no handshake is ignored.
  - flush in the EMIT states is ignored.
- Exit edge effects:
  - On the exit edge, in_ready <= 0 and out_valid <= 1.
  - Latency: final sample edge k gives out_valid=1 in the cycle after edge k.
  - No sample is accepted in that cycle.
- EMIT_LO:
  - out_valid=1, out_data=acc[7:0], out_last=0, busy=1.
  - On out_ready -> EMIT_HI.
- EMIT_HI:
  - out_valid=1, out_data=acc[ACC_W-1:8] zero-extended to 8 bits, out_last=1, busy=1.
  - On out_ready -> ACCUM.
  - On that edge: acc<=0, cnt<=0, overflow<=0, out_valid<=0, in_ready<=1.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_last and overflow hold stable. out_valid never drops without a handshake.
- overflow is valid for the frame being emitted and is cleared only on the EMIT_HI handshake.
- Back-to-back: out_ready held high gives minimum frame period N_SAMPLES+2 cycles.
- in_valid is ignored while in_ready=0. Upstream must hold its data; no sample is lost or double-counted.
- out_ready while out_valid=0 has no effect.
- Reset mid-frame or mid-emit: immediate return to reset values. The partial frame is discarded and no byte is emitted.
- All outputs are registered or decoded directly from the state register. No combinational path from in_* to out_*.

Test Plan:
- Frame sum: N=4, ACC_W=16; samples 10,20,30,40, out_ready=1 -> bytes 0x64 (last=0) then 0x00 (last=1), overflow=0; out_valid rises the cycle after the 4th handshake.
- Max value: samples 255×4 -> 0xFC then 0x03, overflow=0.
- Overflow: ACC_W=9, N=4, samples 255×4 -> 1020 mod 512 = 508 -> 0xFC then 0x01, overflow=1 held through both bytes, 0 after the EMIT_HI handshake.
- Flush: samples 5,7, then flush with in_valid=0 -> 0x0C, 0x00. A third case, sample 3 with flush in the same cycle -> 0x0F, 0x00. flush alone with cnt=0 -> no output.
- Backpressure: out_ready=0 for 5 cycles in EMIT_LO -> out_data stable, in_ready=0, in_valid pulses ignored; release -> both bytes; next frame counts from 0.
- Reset: assert rst_n=0 after 2 samples and again during EMIT_HI -> all outputs 0 immediately, in_ready=1 one edge after release; next full frame sums only post-reset samples.
